// File: rtl/router_port_arb.sv
// rtl/router_port_arb.sv - round-robin output-port arbiter with frame watchdog and inter-frame gap
//
// Purpose: picks which input port may start a frame on this router output,
// holds the grant until that port's EOF is accepted, then forces an idle gap.
// Ports:
//   CLK      clock
//   RST      synchronous, active-high reset
//   REQ      per-port frame request, level, held until granted
//   EOF      per-port end-of-frame; only the granted port's bit is used
//   Q_BP     downstream backpressure, 1 = current beat not accepted
//   GNT      one-hot grant / output mux select, zero when no frame is active
//   BUSY     high while a grant is held
//   HOLD     REQ & ~GNT, stall indication for waiting ports (combinational)
//   ABORT    one-cycle pulse when the frame watchdog forcibly releases the grant
//   CUR_SRC  binary index of the last granted port
module router_port_arb #(
    parameter int NumPorts    = 4,
    parameter int GapCycles   = 2,
    parameter int MaxFrameCyc = 1024,
    localparam int PW         = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NumPorts-1:0] REQ,
    input  logic [NumPorts-1:0] EOF,
    input  logic                Q_BP,
    output logic [NumPorts-1:0] GNT,
    output logic                BUSY,
    output logic [NumPorts-1:0] HOLD,
    output logic                ABORT,
    output logic [PW-1:0]       CUR_SRC
);

    localparam int FCW = (MaxFrameCyc > 0) ? $clog2(MaxFrameCyc + 1) : 1;
    localparam int GW  = (GapCycles > 0) ? $clog2(GapCycles + 1) : 1;

    localparam bit           WDOG_EN  = (MaxFrameCyc != 0);
    localparam logic [FCW-1:0] FC_LAST  = FCW'((MaxFrameCyc > 0) ? MaxFrameCyc - 1 : 0);
    localparam logic [FCW-1:0] FC_MAX   = FCW'(MaxFrameCyc);
    localparam logic [GW-1:0]  GAP_LAST = GW'((GapCycles > 0) ? GapCycles - 1 : 0);
    localparam logic [PW-1:0]  PTR_RST  = PW'(NumPorts - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         cur_src_q, cur_src_d;
    logic [FCW-1:0]        fc_q, fc_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [NumPorts-1:0]   gnt_q, gnt_d;
    logic                  busy_q, busy_d;
    logic                  abort_q, abort_d;

    logic                  win_found;
    logic [PW-1:0]         win_idx;
    logic                  eof_cur;
    logic                  expire;
    logic                  release_ok;

    // Round-robin search starting just after the last winner. The wrap is an
    // explicit subtraction so non-power-of-two port counts rotate correctly.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NumPorts; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NumPorts) begin
                cand = cand - NumPorts;
            end
            if (!win_found && REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
    end

    assign eof_cur = EOF[cur_src_q];

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_RST;
            cur_src_q <= '0;
            fc_q      <= '0;
            gap_q     <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cur_src_q <= cur_src_d;
            fc_q      <= fc_d;
            gap_q     <= gap_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            abort_q   <= abort_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_src_d  = cur_src_q;
        fc_d       = fc_q;
        gap_d      = gap_q;
        expire     = 1'b0;
        release_ok = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d   = S_BUSY;
                    ptr_d     = win_idx;
                    cur_src_d = win_idx;
                    fc_d      = '0;
                end
            end
            S_BUSY: begin
                if (!Q_BP) begin
                    // An EOF accepted on the expiry beat wins over the watchdog.
                    if (eof_cur) begin
                        release_ok = 1'b1;
                    end else if (WDOG_EN && (fc_q == FC_LAST)) begin
                        expire = 1'b1;
                    end else if (fc_q != FC_MAX) begin
                        fc_d = fc_q + FCW'(1);
                    end
                    if (release_ok || expire) begin
                        state_d = (GapCycles > 0) ? S_GAP : S_IDLE;
                        gap_d   = '0;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: registered outputs are derived from the state being entered.
    always_comb begin
        gnt_d = '0;
        if (state_d == S_BUSY) begin
            gnt_d[cur_src_d] = 1'b1;
        end
        busy_d  = (state_d == S_BUSY);
        abort_d = expire;
    end

    assign GNT     = gnt_q;
    assign BUSY    = busy_q;
    assign ABORT   = abort_q;
    assign CUR_SRC = cur_src_q;
    assign HOLD    = REQ & ~gnt_q;

endmodule

// File: tb/tb_router_port_arb.sv
// tb/tb_router_port_arb.sv - self-checking bench for router_port_arb
module tb_router_port_arb;

    localparam int NP   = 4;
    localparam int GAP  = 2;
    localparam int MAXF = 8;

    logic          CLK = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] req = '0;
    logic [NP-1:0] eof = '0;
    logic          q_bp = 1'b0;
    logic [NP-1:0] gnt, hold;
    logic          busy, abort;
    logic [1:0]    cur;

    logic [NP-1:0] req2 = '0;
    logic [NP-1:0] eof2 = '0;
    logic [NP-1:0] gnt2, hold2;
    logic          busy2, abort2;
    logic [1:0]    cur2;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    router_port_arb #(.NumPorts(NP), .GapCycles(GAP), .MaxFrameCyc(MAXF)) u_dut (
        .CLK(CLK), .RST(rst), .REQ(req), .EOF(eof), .Q_BP(q_bp),
        .GNT(gnt), .BUSY(busy), .HOLD(hold), .ABORT(abort), .CUR_SRC(cur)
    );

    router_port_arb #(.NumPorts(NP), .GapCycles(0), .MaxFrameCyc(MAXF)) u_dut_nogap (
        .CLK(CLK), .RST(rst), .REQ(req2), .EOF(eof2), .Q_BP(1'b0),
        .GNT(gnt2), .BUSY(busy2), .HOLD(hold2), .ABORT(abort2), .CUR_SRC(cur2)
    );

    // Behavioural reference: mode 0 idle, 1 frame in progress, 2 gap.
    int            m_mode = 0;
    int            m_ptr = NP - 1;
    int            m_owner = 0;
    int            m_beats = 0;
    int            m_gap = 0;
    logic [NP-1:0] exp_gnt = '0;
    logic          exp_busy = 1'b0;
    logic          exp_abort = 1'b0;
    int            exp_cur = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit found;
        exp_abort = 1'b0;
        if (rst) begin
            m_mode  = 0;
            m_ptr   = NP - 1;
            exp_cur = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (req != '0) begin
                        found = 0;
                        for (int k = 1; k <= NP; k++) begin
                            int p;
                            p = (m_ptr + k) % NP;
                            if (!found && req[p]) begin
                                found   = 1;
                                m_owner = p;
                            end
                        end
                        m_ptr   = m_owner;
                        exp_cur = m_owner;
                        m_beats = 0;
                        m_mode  = 1;
                    end
                end
                1: begin
                    if (!q_bp) begin
                        if (eof[m_owner]) begin
                            m_mode = (GAP > 0) ? 2 : 0;
                            m_gap  = GAP;
                        end else begin
                            m_beats++;
                            if (MAXF != 0 && m_beats >= MAXF) begin
                                exp_abort = 1'b1;
                                m_mode    = (GAP > 0) ? 2 : 0;
                                m_gap     = GAP;
                            end
                        end
                    end
                end
                default: begin
                    m_gap--;
                    if (m_gap == 0) m_mode = 0;
                end
            endcase
        end
        exp_busy = (m_mode == 1);
        exp_gnt  = exp_busy ? NP'(1 << m_owner) : '0;
    endtask

    // One clock: advance the model with the applied inputs, then compare.
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("busy", 32'(busy), 32'(exp_busy));
        check("abort", 32'(abort), 32'(exp_abort));
        check("cur_src", 32'(cur), 32'(exp_cur));
        check("hold", 32'(hold), 32'(req & ~exp_gnt));
    endtask

    task automatic wait_grant(output int zeros);
        zeros = 0;
        while (gnt === '0 && zeros < 30) begin
            zeros++;
            tick();
        end
        check("grant_timeout", 32'(zeros < 30), 32'd1);
    endtask

    task automatic release_frame();
        eof  = '1;
        q_bp = 1'b0;
        tick();
        check("release_gnt", 32'(gnt), 32'd0);
        eof = '0;
    endtask

    initial begin
        int z;
        int acc;
        logic [NP-1:0] seq [4];
        logic [NP-1:0] seq2 [8];
        seq  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq2 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};

        // Reset with all ports requesting; port 0 must win first.
        rst = 1'b1;
        req = 4'b1111;
        repeat (3) tick();
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_cur", 32'(cur), 32'd0);
        rst = 1'b0;
        tick();
        check("first_gnt", 32'(gnt), 32'b0001);
        for (int i = 0; i < 4; i++) begin
            release_frame();
            wait_grant(z);
            check("gap_len", 32'(z), 32'd3);
            check("rr_order", 32'(gnt), 32'(seq[i]));
        end

        // Skip and wrap from PTR=2.
        release_frame();
        req = 4'b0100;
        wait_grant(z);
        check("grant_p2", 32'(gnt), 32'b0100);
        release_frame();
        req = 4'b0011;
        wait_grant(z);
        check("wrap_p0", 32'(gnt), 32'b0001);
        release_frame();
        req = 4'b0010;
        wait_grant(z);
        check("only_p1", 32'(gnt), 32'b0010);

        // EOF under backpressure is not accepted.
        req  = 4'b0000;
        eof  = 4'b0010;
        q_bp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold", 32'(gnt), 32'b0010);
        end
        q_bp = 1'b0;
        tick();
        check("bp_release", 32'(gnt), 32'd0);
        eof = '0;

        // Watchdog with no backpressure.
        req = 4'b1000;
        wait_grant(z);
        check("grant_p3", 32'(gnt), 32'b1000);
        req = '0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("wd_no_abort", 32'(abort), 32'd0);
        end
        tick();
        check("wd_abort", 32'(abort), 32'd1);
        check("wd_gnt", 32'(gnt), 32'd0);
        tick();
        check("wd_pulse", 32'(abort), 32'd0);

        // Watchdog counts accepted beats only.
        req = 4'b1000;
        wait_grant(z);
        req = '0;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            q_bp = i[0];
            if (!q_bp) acc++;
            tick();
            if (abort) break;
        end
        check("wd_accepted", 32'(acc), 32'(MAXF));
        q_bp = 1'b0;

        // Stray EOF on a non-granted port.
        req = 4'b0001;
        wait_grant(z);
        check("grant_p0", 32'(gnt), 32'b0001);
        req = 4'b0101;
        eof = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray_gnt", 32'(gnt), 32'b0001);
            check("stray_hold", 32'(hold), 32'b0100);
        end
        release_frame();

        // Reset mid-frame.
        req = 4'b0100;
        wait_grant(z);
        check("grant_p2b", 32'(gnt), 32'b0100);
        rst = 1'b1;
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        rst = 1'b0;
        req = 4'b1111;
        tick();
        check("rst_ptr", 32'(gnt), 32'b0001);
        release_frame();
        req = '0;

        // GapCycles=0: back-to-back frames separated by one idle cycle.
        req2 = 4'b1111;
        eof2 = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("nogap_seq", 32'(gnt2), 32'(seq2[i]));
        end
        req2 = '0;
        eof2 = '0;

        // Randomized traffic against the reference.
        for (int i = 0; i < 500; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            req  = NP'($urandom);
            eof  = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
            q_bp = ($urandom_range(0, 9) < 3);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
